instruction_sequencer: RTL

//   Front end of the control unit: turns raw board buttons/switches into clean single-cycle

---
 rtl/instruction_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// Button front end for the control unit: synchronises and debounces step/load buttons
// and turns accepted presses into single-cycle execute or instruction-memory write strobes.
module instruction_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned IM_DEPTH        = 8,
    parameter int unsigned INSTR_W         = 12,
    localparam int unsigned CNT_W          = $clog2(IM_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_step,
    input  logic               btn_load,
    input  logic               sw_external,
    input  logic [INSTR_W-1:0] sw_data,
    output logic               nextinstruction,
    output logic               isexternal,
    output logic               IM_we,
    output logic [INSTR_W-1:0] IM_wd,
    output logic [CNT_W-1:0]   load_count,
    output logic               busy
);

    localparam int unsigned     BTN_N    = 2;
    localparam int unsigned     BTN_STEP = 0;
    localparam int unsigned     BTN_LOAD = 1;
    localparam int unsigned     DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        LOAD,
        RELEASE
    } state_t;

    logic [BTN_N-1:0] sync1;
    logic [BTN_N-1:0] sync2;
    logic [BTN_N-1:0] deb;
    logic [BTN_N-1:0] deb_q;
    logic [DB_W-1:0]  db_cnt [BTN_N];

    logic   step_evt_c;
    logic   load_evt_c;
    logic   capture_c;
    state_t state;
    state_t state_d;

    // Two-flop synchroniser plus stability counter; a level is accepted only after
    // DEBOUNCE_CYCLES consecutive differing samples, any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < int'(BTN_N); i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {btn_load, btn_step};
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < int'(BTN_N); i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    deb[i]    <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign step_evt_c = deb[BTN_STEP] & ~deb_q[BTN_STEP];
    assign load_evt_c = deb[BTN_LOAD] & ~deb_q[BTN_LOAD];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state; load beats step only in external mode, a plain load press is swallowed.
    always_comb begin
        state_d   = state;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (load_evt_c && sw_external) begin
                    state_d   = LOAD;
                    capture_c = 1'b1;
                end else if (step_evt_c) begin
                    state_d   = STEP;
                    capture_c = 1'b1;
                end else if (load_evt_c) begin
                    state_d = RELEASE;
                end
            end
            STEP:    state_d = RELEASE;
            LOAD:    state_d = RELEASE;
            RELEASE: begin
                if (deb == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so strobes line up with STEP/LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nextinstruction <= 1'b0;
            IM_we           <= 1'b0;
            busy            <= 1'b0;
            isexternal      <= 1'b0;
            IM_wd           <= '0;
            load_count      <= '0;
        end else begin
            nextinstruction <= (state_d == STEP);
            IM_we           <= (state_d == LOAD);
            busy            <= (state_d != IDLE);
            if (state == IDLE) begin
                isexternal <= sw_external;
            end
            if (capture_c) begin
                IM_wd <= sw_data;
            end
            if ((state_d == LOAD) && (load_count != CNT_MAX)) begin
                load_count <= load_count + CNT_W'(1);
            end
        end
    end

endmodule
